// File: rtl/score_uart_reporter.sv
// Sends the two BCD score digits over UART 8N1 as "<tens><units>\r\n".
// Optional macro SCORE_AUTO_SEND_EN: also send automatically whenever the score changes.
module score_uart_reporter #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    snap_q, snap_d;
    logic          pend_q, pend_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [7:0] score;
    logic [7:0] cur_byte;
    logic [2:0] bit_next;
    logic       bit_done;
    logic       trigger;
    logic       busy_req;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : 8'h30 + {4'h0, n};
    endfunction

    assign score    = {dig1, dig0};
    assign bit_next = bit_q + 3'd1;
    assign bit_done = (cnt_q == CNT_MAX);

`ifdef SCORE_AUTO_SEND_EN
    logic [7:0] last_q, last_d;
    assign trigger  = send || pend_q || (score != last_q);
    assign busy_req = send || (score != snap_q);
`else
    assign trigger  = send || pend_q;
    assign busy_req = send;
`endif

    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = to_ascii(snap_q[7:4]);
            2'd1:    cur_byte = to_ascii(snap_q[3:0]);
            2'd2:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        // NOTE: every _d is defaulted to hold before the case, so no branch can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        pend_d  = pend_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SCORE_AUTO_SEND_EN
        last_d  = last_q;
`endif
        // Requests arriving mid-message collapse into one follow-up.
        if (state_q != IDLE && busy_req) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    snap_d  = score;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_next;
                        tx_d  = cur_byte[bit_next];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = NEXT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NEXT: begin
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    tx_d    = 1'b0;
                    state_d = START;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef SCORE_AUTO_SEND_EN
                    last_d  = snap_q;
`endif
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            pend_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SCORE_AUTO_SEND_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            pend_q  <= pend_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SCORE_AUTO_SEND_EN
            last_q  <= last_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_score_uart_reporter.sv
// Randomized bench for score_uart_reporter: a UART receiver model decodes tx and
// compares against messages predicted from the score; a second instance runs at the minimum bit period.
module tb_score_uart_reporter;
    localparam int CPB_A = 4;
    localparam int CPB_B = 2;
    localparam int MSG_A = 4 * 10 * CPB_A + 4;
    localparam int MSG_B = 4 * 10 * CPB_B + 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] dig0_a = 4'd0, dig1_a = 4'd0, dig0_b = 4'd0, dig1_b = 4'd0;
    logic       send_a = 1'b0, send_b = 1'b0;
    logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_a[$], rx_b[$], exp_a[$], exp_b[$];
    int runs_a[$], runs_b[$], gaps_a[$];
    int done_cnt_a = 0, done_cnt_b = 0;

    score_uart_reporter #(.CLKS_PER_BIT(CPB_A)) dut (
        .clk(clk), .reset(reset), .dig0(dig0_a), .dig1(dig1_a), .send(send_a),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    score_uart_reporter #(.CLKS_PER_BIT(CPB_B)) dut_min (
        .clk(clk), .reset(reset), .dig0(dig0_b), .dig1(dig1_b), .send(send_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ascii_of(input logic [3:0] d);
        if (d > 4'd9) return 8'h3F;
        return 8'h30 + {4'h0, d};
    endfunction

    task automatic push_exp(input int which, input logic [3:0] d1, input logic [3:0] d0);
        logic [7:0] msg[4];
        msg[0] = ascii_of(d1);
        msg[1] = ascii_of(d0);
        msg[2] = 8'h0D;
        msg[3] = 8'h0A;
        for (int i = 0; i < 4; i++) begin
            if (which == 0) exp_a.push_back(msg[i]);
            else            exp_b.push_back(msg[i]);
        end
    endtask

    function automatic logic tx_of(input int which);
        return (which == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic busy_of(input int which);
        return (which == 0) ? busy_a : busy_b;
    endfunction

    function automatic int rx_size(input int which);
        return (which == 0) ? rx_a.size() : rx_b.size();
    endfunction

    task automatic step(input int n, inout logic bad);
        repeat (n) begin
            @(negedge clk);
            if (reset) bad = 1'b1;
        end
    endtask

    // UART receiver model: finds the start bit, samples each bit mid-period.
    task automatic rx_mon(input int which, input int cpb);
        logic [7:0] b;
        logic       bad;
        forever begin
            @(negedge clk);
            if (!reset && tx_of(which) == 1'b0) begin
                bad = 1'b0;
                b   = 8'h00;
                step(cpb / 2, bad);
                if (!bad) check("start_bit", tx_of(which), 1'b0);
                for (int k = 0; k < 8; k++) begin
                    step(cpb, bad);
                    b[k] = tx_of(which);
                end
                step(cpb, bad);
                if (!bad) begin
                    check("stop_bit", tx_of(which), 1'b1);
                    if (which == 0) rx_a.push_back(b);
                    else            rx_b.push_back(b);
                end
            end
        end
    endtask

    initial rx_mon(0, CPB_A);
    initial rx_mon(1, CPB_B);

    // busy run lengths, idle gaps before each message, and done alignment.
    initial begin
        int run_a = 0, low_a = 0, run_b = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run_a = 0;
                low_a = 0;
                run_b = 0;
            end else begin
                if (busy_a) begin
                    if (run_a == 0) gaps_a.push_back(low_a);
                    run_a++;
                    low_a = 0;
                end else begin
                    if (run_a > 0) begin
                        runs_a.push_back(run_a);
                        check("done_at_busy_fall_a", done_a, 1'b1);
                    end
                    run_a = 0;
                    low_a++;
                end
                if (busy_b) run_b++;
                else begin
                    if (run_b > 0) begin
                        runs_b.push_back(run_b);
                        check("done_at_busy_fall_b", done_b, 1'b1);
                    end
                    run_b = 0;
                end
                if (done_a) done_cnt_a++;
                if (done_b) done_cnt_b++;
            end
        end
    end

    task automatic clear_a();
        rx_a.delete();
        exp_a.delete();
        runs_a.delete();
        gaps_a.delete();
        done_cnt_a = 0;
    endtask

    task automatic send_pulse_a(input logic [3:0] d1, input logic [3:0] d0);
        @(negedge clk);
        dig1_a = d1;
        dig0_a = d0;
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
    endtask

    task automatic wait_bytes(input int which, input int n, input int budget);
        int c = 0;
        while ((rx_size(which) < n || busy_of(which)) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("wait_in_budget", (c < budget), 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic verify_a(input string tag, input int n_msgs);
        check({tag, "_byte_count"}, rx_a.size(), exp_a.size());
        foreach (exp_a[i])
            if (i < rx_a.size()) check($sformatf("%s_byte%0d", tag, i), rx_a[i], exp_a[i]);
        check({tag, "_busy_runs"}, runs_a.size(), n_msgs);
        foreach (runs_a[i]) check({tag, "_busy_len"}, runs_a[i], MSG_A);
        check({tag, "_done_count"}, done_cnt_a, n_msgs);
    endtask

    initial begin
        logic [3:0] d1, d0;

        #12;
        check("rst_tx", tx_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_tx_min", tx_b, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Nothing is sent without a request (score 00 equals the reset last-sent value).
        repeat (60) @(negedge clk);
        check("idle_no_bytes", rx_a.size(), 0);
        check("idle_no_busy", runs_a.size(), 0);
        check("idle_tx", tx_a, 1'b1);

        // Score 42 with first-cycle latency check.
        clear_a();
        send_pulse_a(4'd4, 4'd2);
        check("latency_busy", busy_a, 1'b1);
        check("latency_tx", tx_a, 1'b0);
        push_exp(0, 4'd4, 4'd2);
        wait_bytes(0, 4, 400);
        verify_a("score42", 1);

        // Non-BCD nibbles encode as '?'.
        clear_a();
        send_pulse_a(4'hA, 4'hF);
        push_exp(0, 4'hA, 4'hF);
        wait_bytes(0, 4, 400);
        verify_a("nonbcd", 1);

        for (int i = 0; i < 6; i++) begin
            clear_a();
            repeat ($urandom_range(0, 20)) @(negedge clk);
            d1 = 4'($urandom_range(0, 15));
            d0 = 4'($urandom_range(0, 15));
            send_pulse_a(d1, d0);
            push_exp(0, d1, d0);
            wait_bytes(0, 4, 400);
            verify_a($sformatf("rand%0d", i), 1);
        end

        // Score changes during byte1 plus three sends collapse into one follow-up.
        clear_a();
        send_pulse_a(4'd1, 4'd2);
        repeat (50) @(negedge clk);
        dig0_a = 4'd3;
        for (int i = 0; i < 3; i++) begin
            repeat (5) @(negedge clk);
            send_a = 1'b1;
            @(negedge clk);
            send_a = 1'b0;
        end
        push_exp(0, 4'd1, 4'd2);
        push_exp(0, 4'd1, 4'd3);
        wait_bytes(0, 8, 1000);
        verify_a("coalesce", 2);
        if (gaps_a.size() >= 2) check("coalesce_gap", gaps_a[1], 1);
        else check("coalesce_gap_count", gaps_a.size(), 2);
        repeat (200) @(negedge clk);
        check("coalesce_no_third", rx_a.size(), 8);

        // Reset during DATA of byte2 (bit1 of 0x0D is low).
        clear_a();
        send_pulse_a(4'd5, 4'd7);
        repeat (91) @(negedge clk);
        check("pre_reset_tx_low", tx_a, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("abort_tx", tx_a, 1'b1);
        check("abort_busy", busy_a, 1'b0);
        check("abort_done", done_a, 1'b0);
        dig1_a = 4'd0;
        dig0_a = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("abort_bytes_kept", rx_a.size(), 2);
        check("abort_no_done", done_cnt_a, 0);
        check("abort_no_busy_run", runs_a.size(), 0);
        check("abort_tx_idle", tx_a, 1'b1);

`ifdef SCORE_AUTO_SEND_EN
        // Score changes trigger by themselves; two changes mid-message yield one message.
        clear_a();
        @(negedge clk);
        dig0_a = 4'd1;
        repeat (30) @(negedge clk);
        dig0_a = 4'd5;
        repeat (10) @(negedge clk);
        dig0_a = 4'd6;
        push_exp(0, 4'd0, 4'd1);
        push_exp(0, 4'd0, 4'd6);
        wait_bytes(0, 8, 1000);
        verify_a("auto", 2);
        repeat (300) @(negedge clk);
        check("auto_hold_no_more", rx_a.size(), 8);
`endif

        // Minimum bit period instance.
        @(negedge clk);
        dig1_b = 4'd9;
        dig0_b = 4'd9;
        send_b = 1'b1;
        @(negedge clk);
        send_b = 1'b0;
        push_exp(1, 4'd9, 4'd9);
        wait_bytes(1, 4, 400);
        check("min_byte_count", rx_b.size(), exp_b.size());
        foreach (exp_b[i])
            if (i < rx_b.size()) check($sformatf("min_byte%0d", i), rx_b[i], exp_b[i]);
        check("min_busy_runs", runs_b.size(), 1);
        foreach (runs_b[i]) check("min_busy_len", runs_b[i], MSG_B);
        check("min_done_count", done_cnt_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
